av2_mv_decode_sched: RTL and testbench



---
 rtl/av2_inter_pkg.sv | 35 +++
 rtl/av2_rr_arbiter.sv | 31 +++
 rtl/av2_mv_decode_sched.sv | 173 +++++++++++++++++
 tb/tb_av2_mv_decode_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_inter_pkg.sv
// Shared types and constants for the AV2 inter-block schedulers: FSM states,
// MV width, packed MV type and the saturating predictor add.
package av2_inter_pkg;

  localparam int MV_W         = 16;
  localparam int MV_LIMIT_DEF = 16383;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT_MV = 2'd2,
    ST_OUT     = 2'd3
  } schedState_e;

  typedef struct packed {
    logic signed [MV_W-1:0] x;
    logic signed [MV_W-1:0] y;
  } av2_mv_t;

  // Sum in 17 bits so the clamp sees the true value before truncation.
  function automatic logic [MV_W-1:0] satAdd(input logic [MV_W-1:0] a,
                                             input logic [MV_W-1:0] b,
                                             input int              limit);
    logic signed [MV_W:0] sum;
    sum = $signed({a[MV_W-1], a}) + $signed({b[MV_W-1], b});
    if (int'(sum) > limit) begin
      satAdd = MV_W'(limit);
    end else if (int'(sum) < -limit) begin
      satAdd = MV_W'(-limit);
    end else begin
      satAdd = sum[MV_W-1:0];
    end
  endfunction

endpackage

// File: rtl/av2_rr_arbiter.sv
// Combinational round-robin select: first set request at or after the
// pointer, searching upward with wrap. Shared by the inter-block schedulers.
module av2_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = PW'((int'(ptr_i) + off) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/av2_mv_decode_sched.sv
// Shares one MV decoder between NUM_REQ requesters: round-robin grant, decoder
// start/capture sequencing, predictor add with saturation, per-MV timeout.
import av2_inter_pkg::*;

module av2_mv_decode_sched #(
  parameter int NUM_REQ  = 4,
  parameter int IDW      = 8,
  parameter int MV_LIMIT = MV_LIMIT_DEF,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_compound,
  input  logic [NUM_REQ*IDW-1:0] req_id,
  input  logic [NUM_REQ*32-1:0] req_pmv,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  dec_start,
  input  logic                  dec_done,
  input  logic [MV_W-1:0]       dec_mv_x,
  input  logic [MV_W-1:0]       dec_mv_y,
  input  logic                  dec_mv_valid,
  output logic                  dec_mv_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic                  res_ref,
  output logic [MV_W-1:0]       res_mv_x,
  output logic [MV_W-1:0]       res_mv_y,
  output logic                  res_err,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  schedState_e          state_q;
  logic [PW-1:0]        rrPtr_q;
  logic [PW-1:0]        winIdx_q;
  logic [IDW-1:0]       id_q;
  av2_mv_t              pmv_q;
  logic                 compound_q;
  logic                 ref_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 decStart_q;
  logic                 resValid_q;
  logic [IDW-1:0]       resId_q;
  logic                 resRef_q;
  av2_mv_t              resMv_q;
  logic                 resErr_q;

  logic [NUM_REQ-1:0]   arbGnt;
  logic [PW-1:0]        arbIdx;
  logic                 arbAny;
  logic [IDW-1:0]       selId;
  av2_mv_t              selPmv;
  logic                 selComp;
  logic [PW-1:0]        nextPtr;

  av2_rr_arbiter #(.N(NUM_REQ), .PW(PW)) uArb (
    .req_i (req),
    .ptr_i (rrPtr_q),
    .gnt_o (arbGnt),
    .idx_o (arbIdx),
    .any_o (arbAny)
  );

  always_comb begin
    selId   = '0;
    selPmv  = '0;
    selComp = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arbGnt[i]) begin
        selId   = req_id[i*IDW +: IDW];
        selPmv  = av2_mv_t'(req_pmv[i*32 +: 32]);
        selComp = req_compound[i];
      end
    end
  end

  assign nextPtr = (winIdx_q == PW'(NUM_REQ - 1)) ? '0 : winIdx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rrPtr_q    <= '0;
      winIdx_q   <= '0;
      id_q       <= '0;
      pmv_q      <= '0;
      compound_q <= 1'b0;
      ref_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      decStart_q <= 1'b0;
      resValid_q <= 1'b0;
      resId_q    <= '0;
      resRef_q   <= 1'b0;
      resMv_q    <= '0;
      resErr_q   <= 1'b0;
    end else begin
      gnt_q      <= '0;
      decStart_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arbAny && dec_done) begin
            gnt_q      <= arbGnt;
            winIdx_q   <= arbIdx;
            id_q       <= selId;
            pmv_q      <= selPmv;
            compound_q <= selComp;
            ref_q      <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (dec_done) begin
            decStart_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_WAIT_MV;
          end
        end
        ST_WAIT_MV: begin
          if (dec_mv_valid) begin
            resMv_q    <= '{x: satAdd(pmv_q.x, dec_mv_x, MV_LIMIT),
                            y: satAdd(pmv_q.y, dec_mv_y, MV_LIMIT)};
            resErr_q   <= 1'b0;
            resId_q    <= id_q;
            resRef_q   <= ref_q;
            resValid_q <= 1'b1;
            state_q    <= ST_OUT;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Abort: return the predictor and drop any pending second MV.
            resMv_q    <= pmv_q;
            resErr_q   <= 1'b1;
            resId_q    <= id_q;
            resRef_q   <= ref_q;
            resValid_q <= 1'b1;
            compound_q <= 1'b0;
            state_q    <= ST_OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            if (compound_q && !ref_q) begin
              ref_q   <= 1'b1;
              state_q <= ST_START;
            end else begin
              rrPtr_q <= nextPtr;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign dec_start    = decStart_q;
  assign dec_mv_ready = (state_q == ST_WAIT_MV) && dec_mv_valid;
  assign res_valid    = resValid_q;
  assign res_id       = resId_q;
  assign res_ref      = resRef_q;
  assign res_mv_x     = resMv_q.x;
  assign res_mv_y     = resMv_q.y;
  assign res_err      = resErr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_av2_mv_decode_sched.sv
// Directed bench for av2_mv_decode_sched: vector table of single/compound
// requests plus hand-written RR, dec_done, timeout, backpressure and reset cases.
module tb_av2_mv_decode_sched;

  localparam int NR  = 4;
  localparam int IDW = 8;

  typedef struct {
    int          idx;
    bit          comp;
    logic [15:0] px, py;
    logic [15:0] d0x, d0y, d1x, d1y;
    int          lat;
    logic [15:0] e0x, e0y, e1x, e1y;
  } vec_t;

  typedef struct {
    logic [7:0]  id;
    logic        rf;
    logic [15:0] x, y;
    logic        err;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_compound;
  logic [NR*IDW-1:0] req_id;
  logic [NR*32-1:0]  req_pmv;
  logic [NR-1:0]     gnt;
  logic              dec_start;
  logic              dec_done;
  logic [15:0]       dec_mv_x, dec_mv_y;
  logic              dec_mv_valid;
  logic              dec_mv_ready;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic              res_ref;
  logic [15:0]       res_mv_x, res_mv_y;
  logic              res_err;
  logic              busy;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int gntCyc = -1, startCyc = -1, rvCyc = -1, gntPulses = 0;
  bit prevRv = 1'b0;
  bit continuous = 1'b0;
  bit resReadyNext = 1'b1;
  bit decRespond = 1'b1;
  int decLatency = 0;
  int decCd = -1;
  bit decLastReady = 1'b0;
  logic [31:0] diffQ[$];
  int          gntOrder[$];
  res_t        results[$];
  vec_t        vecs[7];

  av2_mv_decode_sched #(.NUM_REQ(NR), .IDW(IDW), .MV_LIMIT(16383), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_compound(req_compound), .req_id(req_id),
    .req_pmv(req_pmv), .gnt(gnt), .dec_start(dec_start), .dec_done(dec_done),
    .dec_mv_x(dec_mv_x), .dec_mv_y(dec_mv_y), .dec_mv_valid(dec_mv_valid),
    .dec_mv_ready(dec_mv_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_ref(res_ref), .res_mv_x(res_mv_x), .res_mv_y(res_mv_y),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: observe outputs mid-cycle, then drive requesters and the decoder model.
  task automatic stepCycle();
    res_t r;
    @(negedge clk);
    cyc++;
    res_ready = resReadyNext;
    if (gnt != '0) begin
      gntPulses++;
      gntCyc = cyc;
      for (int i = 0; i < NR; i++) if (gnt[i]) gntOrder.push_back(i);
      if (!continuous) req = req & ~gnt;
    end
    if (dec_start) startCyc = cyc;
    if (res_valid && !prevRv) rvCyc = cyc;
    prevRv = res_valid;
    if (res_valid && res_ready) begin
      r.id = res_id; r.rf = res_ref; r.x = res_mv_x; r.y = res_mv_y; r.err = res_err;
      results.push_back(r);
    end
    if (dec_mv_valid && decLastReady) dec_mv_valid = 1'b0;
    if (dec_start && decRespond) decCd = decLatency;
    else if (decCd > 0) decCd--;
    if (decCd == 0) begin
      decCd = -1;
      dec_mv_valid = 1'b1;
      if (diffQ.size() > 0) {dec_mv_x, dec_mv_y} = diffQ.pop_front();
      else {dec_mv_x, dec_mv_y} = '0;
      #1;
      checkOutput("dec_mv_ready", {31'd0, dec_mv_ready}, 32'd1);
    end else begin
      #1;
    end
    decLastReady = dec_mv_ready;
  endtask

  task automatic runUntil(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (!(results.size() >= n && !busy) && k < budget) begin
      stepCycle();
      k++;
    end
    checkOutput(name, {31'd0, (results.size() >= n && !busy)}, 32'd1);
  endtask

  task automatic clearLog();
    gntPulses = 0; gntCyc = -1; startCyc = -1; rvCyc = -1;
    results.delete();
    gntOrder.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    clearLog();
    req_pmv[v.idx*32 +: 32] = {v.px, v.py};
    req_compound[v.idx]     = v.comp;
    decLatency              = v.lat;
    diffQ.push_back({v.d0x, v.d0y});
    if (v.comp) diffQ.push_back({v.d1x, v.d1y});
    req[v.idx] = 1'b1;
  endtask

  task automatic checkVector(input vec_t v, input int n);
    res_t r;
    int   cnt;
    cnt = v.comp ? 2 : 1;
    checkOutput($sformatf("v%0d_count", n), results.size(), cnt);
    checkOutput($sformatf("v%0d_gntPulses", n), gntPulses, 32'd1);
    for (int j = 0; j < cnt && j < results.size(); j++) begin
      r = results[j];
      checkOutput($sformatf("v%0d_r%0d_id", n, j), {24'd0, r.id}, 32'hA0 + v.idx);
      checkOutput($sformatf("v%0d_r%0d_ref", n, j), {31'd0, r.rf}, j);
      checkOutput($sformatf("v%0d_r%0d_err", n, j), {31'd0, r.err}, 32'd0);
      checkOutput($sformatf("v%0d_r%0d_x", n, j), {16'd0, r.x}, {16'd0, (j == 0) ? v.e0x : v.e1x});
      checkOutput($sformatf("v%0d_r%0d_y", n, j), {16'd0, r.y}, {16'd0, (j == 0) ? v.e0y : v.e1y});
    end
    if (!v.comp) begin
      checkOutput($sformatf("v%0d_startLat", n), startCyc - gntCyc, 32'd1);
      checkOutput($sformatf("v%0d_resLat", n), rvCyc - gntCyc, 2 + v.lat);
    end
  endtask

  initial begin
    vec_t t;
    vecs[0] = '{0, 1'b0, 16'd10, 16'(-5), 16'd3, 16'd4, 16'd0, 16'd0, 2, 16'd13, 16'(-1), 16'd0, 16'd0};
    vecs[1] = '{2, 1'b1, 16'd0, 16'd0, 16'd1, 16'd1, 16'(-2), 16'd0, 1, 16'd1, 16'd1, 16'(-2), 16'd0};
    vecs[2] = '{1, 1'b0, 16'd16000, 16'(-16000), 16'd1000, 16'(-1000), 16'd0, 16'd0, 0, 16'd16383, 16'(-16383), 16'd0, 16'd0};
    vecs[3] = '{3, 1'b0, 16'(-100), 16'd200, 16'(-50), 16'(-300), 16'd0, 16'd0, 3, 16'(-150), 16'(-100), 16'd0, 16'd0};
    vecs[4] = '{0, 1'b0, 16'd16383, 16'(-16383), 16'd0, 16'd0, 16'd0, 16'd0, 1, 16'd16383, 16'(-16383), 16'd0, 16'd0};
    vecs[5] = '{1, 1'b0, 16'd32767, 16'(-32768), 16'd32767, 16'(-32768), 16'd0, 16'd0, 2, 16'd16383, 16'(-16383), 16'd0, 16'd0};
    vecs[6] = '{2, 1'b0, 16'd16384, 16'd0, 16'(-1), 16'(-16384), 16'd0, 16'd0, 1, 16'd16383, 16'(-16383), 16'd0, 16'd0};

    rst = 1'b1; req = '0; req_compound = '0; req_pmv = '0;
    for (int i = 0; i < NR; i++) req_id[i*IDW +: IDW] = IDW'(8'hA0 + i);
    dec_done = 1'b1; dec_mv_x = '0; dec_mv_y = '0; dec_mv_valid = 1'b0; res_ready = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset_outputs", {gnt, dec_start, dec_mv_ready, res_valid, res_ref, res_err, busy},
                32'd0);
    checkOutput("reset_fields", {res_id, res_mv_x[7:0], res_mv_y[7:0]}, 32'd0);
    rst = 1'b0;
    stepCycle();

    // Round robin from pointer 0 with all four requesting.
    $display("[TB] round-robin sequence");
    clearLog();
    continuous = 1'b1; decLatency = 0;
    for (int i = 0; i < 5; i++) diffQ.push_back(32'd0);
    req = '1;
    for (int k = 0; k < 100; k++) begin
      stepCycle();
      if (gntOrder.size() == 5) break;
    end
    req = '0; continuous = 1'b0;
    runUntil(5, 60, "rr_done");
    checkOutput("rr_grants", gntOrder.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_order%0d", i), (i < gntOrder.size()) ? gntOrder[i] : -1, i % 4);
      checkOutput($sformatf("rr_id%0d", i), (i < results.size()) ? {24'd0, results[i].id} : 32'hFFFF,
                  32'hA0 + (i % 4));
    end

    $display("[TB] vector table");
    for (int n = 0; n < 7; n++) begin
      applyStimulus(vecs[n]);
      runUntil(vecs[n].comp ? 2 : 1, 60, $sformatf("v%0d_done", n));
      checkVector(vecs[n], n);
      req_compound = '0;
      stepCycle();
    end

    // No grant while the decoder is not idle.
    $display("[TB] dec_done hold");
    t = '{1, 1'b0, 16'd7, 16'd7, 16'd1, 16'(-1), 16'd0, 16'd0, 1, 16'd8, 16'd6, 16'd0, 16'd0};
    dec_done = 1'b0;
    applyStimulus(t);
    repeat (4) stepCycle();
    checkOutput("hold_noGnt", gntPulses, 32'd0);
    checkOutput("hold_busy", {31'd0, busy}, 32'd0);
    dec_done = 1'b1;
    runUntil(1, 40, "hold_done");
    checkVector(t, 7);

    // Timeout: decoder never answers; compound second MV is dropped.
    $display("[TB] timeout");
    decRespond = 1'b0;
    clearLog();
    req_pmv[1*32 +: 32] = {16'd123, 16'(-77)};
    req_compound[1] = 1'b1;
    req[1] = 1'b1;
    runUntil(1, 40, "to_done");
    repeat (12) stepCycle();
    checkOutput("to_count", results.size(), 32'd1);
    checkOutput("to_gntPulses", gntPulses, 32'd1);
    checkOutput("to_resLat", rvCyc - gntCyc, 32'd9);
    checkOutput("to_busy", {31'd0, busy}, 32'd0);
    if (results.size() > 0) begin
      checkOutput("to_err", {31'd0, results[0].err}, 32'd1);
      checkOutput("to_ref", {31'd0, results[0].rf}, 32'd0);
      checkOutput("to_mv", {results[0].x, results[0].y}, {16'd123, 16'(-77)});
      checkOutput("to_id", {24'd0, results[0].id}, 32'hA1);
    end
    req_compound = '0;
    decRespond = 1'b1;

    // Backpressure: fields must hold while res_ready is low.
    $display("[TB] backpressure");
    t = '{3, 1'b0, 16'd5, 16'd6, 16'd1, 16'd1, 16'd0, 16'd0, 1, 16'd6, 16'd7, 16'd0, 16'd0};
    resReadyNext = 1'b0;
    applyStimulus(t);
    for (int k = 0; k < 20 && !res_valid; k++) stepCycle();
    checkOutput("bp_valid", {31'd0, res_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput($sformatf("bp_hold%0d", k), {res_valid, res_ref, res_err, 5'd0, res_id, res_mv_x},
                  {3'b100, 5'd0, 8'hA3, 16'd6});
      checkOutput($sformatf("bp_holdY%0d", k), {16'd0, res_mv_y}, 32'd7);
    end
    resReadyNext = 1'b1;
    runUntil(1, 20, "bp_done");
    checkVector(t, 8);

    // Reset while waiting on the decoder.
    $display("[TB] reset in WAIT_MV");
    decRespond = 1'b0;
    clearLog();
    req_pmv[0 +: 32] = {16'd9, 16'd9};
    req[0] = 1'b1;
    for (int k = 0; k < 20 && startCyc < 0; k++) stepCycle();
    stepCycle();
    checkOutput("rs_busyBefore", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rs_outputs", {gnt, dec_start, dec_mv_ready, res_valid, res_ref, res_err, busy}, 32'd0);
    checkOutput("rs_fields", {res_id, res_mv_x[7:0], res_mv_y[7:0]}, 32'd0);
    stepCycle();
    checkOutput("rs_idle", {30'd0, busy, res_valid}, 32'd0);
    rst = 1'b0;
    dec_mv_valid = 1'b0; decCd = -1; diffQ.delete(); decRespond = 1'b1;
    clearLog();
    decLatency = 1;
    req_pmv[2*32 +: 32] = {16'd10, 16'd10};
    req_pmv[3*32 +: 32] = {16'(-10), 16'(-10)};
    diffQ.push_back({16'd1, 16'd2});
    diffQ.push_back({16'd3, 16'd4});
    req[2] = 1'b1;
    req[3] = 1'b1;
    runUntil(2, 80, "rs_done");
    checkOutput("rs_first", (gntOrder.size() > 0) ? gntOrder[0] : -1, 32'd2);
    checkOutput("rs_second", (gntOrder.size() > 1) ? gntOrder[1] : -1, 32'd3);
    if (results.size() > 1) begin
      checkOutput("rs_r0", {results[0].x, results[0].y}, {16'd11, 16'd12});
      checkOutput("rs_r1", {results[1].x, results[1].y}, {16'(-7), 16'(-6)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
